muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Sequencer for the shared multiply and divide units in the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX. It drives the operands and start/annul controls to the multiplier and divider, and raises a stall request to CTRL while an operation is in flight. On completion it owns and updates the architectural HI/LO registers.

## Interface
- `MUL_LATENCY`, default 2: cycles from operands applied to `mul_result` valid; legal range 1..15.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX holds a mul/div/HI-LO-move instruction.
- `req_op` in 3: operation select.
  - 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO.
  - Other values are a no-op.
- `req_src1`, `req_src2` in 32: rs and rt operands.
- `ex_hold` in 1: EX register will not advance this cycle (other stall source).
- `cancel` in 1: flush; abort any in-flight operation.
- `mul_signed` out 1, `mul_ina` out 32, `mul_inb` out 32: multiplier controls.
- `mul_result` in 64: multiplier product.
- `div_start` out 1, `div_signed` out 1, `div_opdata1` out 32, `div_opdata2` out 32, `div_annul` out 1: divider controls.
- `div_ready` in 1: divider result valid.
- `div_result` in 64: divider output, {remainder, quotient}.
- `stallreq` out 1: request to stall IF/ID/EX.
- `busy` out 1: FSM not in IDLE or DONE.
- `hi_o`, `lo_o` out 32: architectural HI/LO.

## Operation
**States:** IDLE, MUL_WAIT, DIV_WAIT, DONE. Encode in 2 bits.

**Reset:**
- State is IDLE; HI/LO are 0.
- All outputs are 0, including `stallreq`, `div_start`, `div_annul` and `busy`.

**IDLE**
- `req_valid` with MULT/MULTU:
  - Drive the mul operands from `req_src*`; `mul_signed` = (op==MULT).
  - Latch operands and op; load counter with `MUL_LATENCY-1`.
  - `stallreq`=1; next state MUL_WAIT.
- `req_valid` with DIV/DIVU:
  - `div_start`=1, `div_signed` = (op==DIV), operands from `req_src*`.
  - Latch operands and op; `stallreq`=1; next state DIV_WAIT.
- MTHI/MTLO: HI (resp. LO) <= `req_src1` at clock edge. No stall, state stays IDLE. Repeated writes while `ex_hold` is high are harmless.

**MUL_WAIT**
- Operands come from the latched copies.
- Counter decrements each cycle.
- Completion cycle, when counter==0:
  - `stallreq`=0.
  - {HI, LO} <= `mul_result` at the edge.
  - Next state DONE if `ex_hold`, else IDLE.
- All other cycles: `stallreq`=1.

**DIV_WAIT**
- Operands come from the latched copies; `div_start`=1 while `div_ready`=0, with `stallreq`=1.
- Completion cycle, when `div_ready`=1:
  - `div_start`=0, `stallreq`=0.
  - HI <= `div_result[63:32]`, LO <= `div_result[31:0]`.
  - Next state DONE if `ex_hold`, else IDLE.

**DONE**
- Result has already been committed; the same instruction is still sitting in EX.
- No start is issued; `stallreq`=0.
- Next state IDLE on the first cycle `ex_hold`=0.

**Cancel**
- `cancel` has priority in any state.
- Next state IDLE; `div_annul`=1 for that cycle if the state is DIV_WAIT.
- HI/LO are not written; no MTHI/MTLO write occurs that cycle.

**Divide by zero:** the divider's result is committed unchanged. No trap is raised.

**Reset mid-operation:** `rst` overrides `cancel` and everything else. It forces the reset values above in the next cycle.

## Timing
- **Latency:**
  - MULT: completion is `MUL_LATENCY` cycles after the accept cycle; stall cycles = `MUL_LATENCY`.
  - DIV: stall lasts from the accept cycle until the cycle before `div_ready`.
- **Stall shape:** `stallreq` is combinational from state, counter and `div_ready`. It is low in the completion cycle, so EX advances on the same edge that writes HI/LO.
- **Operand stability:** `req_*` are guaranteed stable only in the accept cycle; latched copies are used afterwards.

## Configuration
`HILO_BYPASS_EN`:
- **Defined:** `hi_o`/`lo_o` combinationally present the value being written this cycle (MTHI/MTLO or a completion). An MFHI/MFLO in the next instruction sees it with no extra stall.
- **Undefined:** `hi_o`/`lo_o` are the register outputs only; a new value is visible one cycle after the write edge.

## Test plan
- **Reset:** `rst` 1 cycle → `hi_o`=`lo_o`=0, `stallreq`=0, `busy`=0.
- **MULT:** MULT -3×5 with `MUL_LATENCY`=2 → `stallreq` high 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIVU, then DIV:**
  - DIVU 100/7 with divider ready after 33 cycles → `div_start` high through the stall; HI=2, LO=14.
  - DIV -7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- **MTHI then MTLO:** MTHI 0x12345678, then MTLO 0x9ABCDEF0 → no stall; registers hold both values; bypass timing checked per macro.
- **Cancel:** `cancel` in the 5th cycle of DIV_WAIT → `div_annul` pulses 1 cycle, state IDLE, HI/LO unchanged.
- **Completion under `ex_hold`:** MULTU completes with `ex_hold`=1 for 3 cycles → state DONE, exactly one HI/LO write, no restart, IDLE when `ex_hold` drops.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences the shared mul/div units and owns HI/LO.
// Optional macro HILO_BYPASS_EN forwards the HI/LO write value to hi_o/lo_o.
module muldiv_sched #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        ex_hold,
    input  logic        cancel,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {
        IDLE, MUL_WAIT, DIV_WAIT, DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        idle_req, acc_mul, acc_div;

    assign idle_req = (state_q == IDLE) && req_valid
                   && !cancel && !rst;
    assign acc_mul  = idle_req
                   && (req_op == OP_MULT || req_op == OP_MULTU);
    assign acc_div  = idle_req
                   && (req_op == OP_DIV || req_op == OP_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acc_mul || acc_div) begin
                        a_d   = req_src1;
                        b_d   = req_src2;
                        sgn_d = (req_op == OP_MULT)
                             || (req_op == OP_DIV);
                    end
                    if (acc_mul) begin
                        cnt_d   = CNT_INIT;
                        state_d = MUL_WAIT;
                    end
                    if (acc_div)
                        state_d = DIV_WAIT;
                    if (idle_req && req_op == OP_MTHI)
                        hi_d = req_src1;
                    if (idle_req && req_op == OP_MTLO)
                        lo_d = req_src1;
                end
                MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = mul_result;
                        state_d = ex_hold ? DONE : IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DIV_WAIT: begin
                    if (div_ready) begin
                        hi_d    = div_result[63:32];
                        lo_d    = div_result[31:0];
                        state_d = ex_hold ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!ex_hold)
                        state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Accept cycle uses live operands; wait states use the latched copies.
    assign mul_signed  = acc_mul ? (req_op == OP_MULT) : sgn_q;
    assign mul_ina     = acc_mul ? req_src1 : a_q;
    assign mul_inb     = acc_mul ? req_src2 : b_q;
    assign div_signed  = acc_div ? (req_op == OP_DIV) : sgn_q;
    assign div_opdata1 = acc_div ? req_src1 : a_q;
    assign div_opdata2 = acc_div ? req_src2 : b_q;

    assign div_start = acc_div
                    || (state_q == DIV_WAIT && !div_ready && !cancel);
    assign div_annul = cancel && (state_q == DIV_WAIT);
    assign stallreq  = acc_mul || acc_div
                    || (state_q == MUL_WAIT && cnt_q != '0)
                    || (state_q == DIV_WAIT && !div_ready);
    assign busy      = (state_q == MUL_WAIT)
                    || (state_q == DIV_WAIT);

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_d;
    assign lo_o = lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: vector table, hand sequences and random ops
// against behavioural multiplier/divider and HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_sched;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        ex_hold = 1'b0;
    logic        cancel = 1'b0;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul;
    logic [31:0] div_opdata1, div_opdata2;
    logic        div_ready;
    logic [63:0] div_result;
    logic        stallreq, busy;
    logic [31:0] hi_o, lo_o;

    always #5 clk = ~clk;

    muldiv_sched #(.MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .ex_hold(ex_hold), .cancel(cancel),
        .mul_signed(mul_signed), .mul_ina(mul_ina),
        .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_annul(div_annul), .div_ready(div_ready),
        .div_result(div_result), .stallreq(stallreq),
        .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
    );

    function automatic logic [63:0] ref_mul(
        input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        return 64'(x * y);
    endfunction

    // Divide by zero: this divider model returns {dividend, all ones}.
    function automatic logic [63:0] ref_div(
        input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {32'(r), 32'(q)};
    endfunction

    logic [63:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= ref_mul(mul_signed, mul_ina, mul_inb);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[L-1];

    int          dlat = 33;
    int          dcnt = 0;
    logic        drun = 1'b0;
    logic [63:0] dres = '0;
    always @(posedge clk) begin
        if (rst || div_annul || div_ready) begin
            drun <= 1'b0;
        end else if (drun) begin
            dcnt <= dcnt + 1;
        end else if (div_start) begin
            drun <= 1'b1;
            dcnt <= 1;
            dres <= ref_div(div_signed, div_opdata1, div_opdata2);
        end
    end
    assign div_ready  = drun && (dcnt == dlat);
    assign div_result = div_ready ? dres : 64'hDEAD_BEEF_DEAD_BEEF;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int stalls);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_src1 = a;
        req_src2 = b;
        #1;
        stalls = 0;
        guard = 0;
        while (stallreq && guard < 200) begin
            if (op == 3'd3 || op == 3'd4)
                chk("div_start_in_stall", 64'(div_start), 64'd1);
            stalls++;
            guard++;
            @(negedge clk);
            req_src1 = $urandom;
            req_src2 = $urandom;
            #1;
        end
        chk("stall_bound", 64'(guard >= 200), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = '0;
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          dl;
        logic [31:0] hi, lo;
        int          st;
    } vec_t;

    vec_t        tv[9];
    int          st;
    logic [31:0] mhi, mlo;
    logic [63:0] r64;
    logic [31:0] a, b;
    logic [2:0]  op;
    int          exp_st;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5, 33,
                  32'hFFFF_FFFF, 32'hFFFF_FFF1, L};
        tv[1] = '{3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14, 33};
        tv[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 33,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        tv[3] = '{3'd5, 32'h1234_5678, 32'd0, 33,
                  32'h1234_5678, 32'hFFFF_FFFD, 0};
        tv[4] = '{3'd6, 32'h9ABC_DEF0, 32'd0, 33,
                  32'h1234_5678, 32'h9ABC_DEF0, 0};
        tv[5] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 33,
                  32'd1, 32'hFFFF_FFFE, L};
        tv[6] = '{3'd3, 32'd5, 32'd0, 4,
                  32'd5, 32'hFFFF_FFFF, 4};
        tv[7] = '{3'd7, 32'd1, 32'd1, 4,
                  32'd5, 32'hFFFF_FFFF, 0};
        tv[8] = '{3'd4, 32'd9, 32'd3, 1, 32'd0, 32'd3, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_div_annul", 64'(div_annul), 64'd0);

        for (int i = 0; i < 9; i++) begin
            dlat = tv[i].dl;
            run_op(tv[i].op, tv[i].a, tv[i].b, st);
            chk($sformatf("vec%0d_hi", i), 64'(hi_o), 64'(tv[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo_o), 64'(tv[i].lo));
            chk($sformatf("vec%0d_stall", i), 64'(st), 64'(tv[i].st));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
        end
        mhi = 32'd0;
        mlo = 32'd3;

        // MTHI then MTLO back to back: no stall, bypass visibility
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd5;
        req_src1 = 32'hCAFE_F00D;
        #1;
        chk("mthi_nostall", 64'(stallreq), 64'd0);
`ifdef HILO_BYPASS_EN
        chk("mthi_same_cycle", 64'(hi_o), 64'hCAFE_F00D);
`else
        chk("mthi_same_cycle", 64'(hi_o), 64'(mhi));
`endif
        @(negedge clk);
        req_op = 3'd6;
        req_src1 = 32'h0BAD_BEEF;
        #1;
        chk("mthi_next_cycle", 64'(hi_o), 64'hCAFE_F00D);
        chk("mtlo_nostall", 64'(stallreq), 64'd0);
`ifdef HILO_BYPASS_EN
        chk("mtlo_same_cycle", 64'(lo_o), 64'h0BAD_BEEF);
`else
        chk("mtlo_same_cycle", 64'(lo_o), 64'(mlo));
`endif
        @(negedge clk);
        req_valid = 1'b0;
        req_op = '0;
        #1;
        chk("mtlo_next_cycle", 64'(lo_o), 64'h0BAD_BEEF);
        mhi = 32'hCAFE_F00D;
        mlo = 32'h0BAD_BEEF;

        // cancel in the 5th DIV_WAIT cycle
        dlat = 33;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd4;
        req_src1 = 32'd1000;
        req_src2 = 32'd3;
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_op = '0;
            #1;
        end
        @(negedge clk);
        cancel = 1'b1;
        #1;
        chk("cancel_annul", 64'(div_annul), 64'd1);
        chk("cancel_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_annul_pulse", 64'(div_annul), 64'd0);
        chk("cancel_idle", 64'(busy), 64'd0);
        chk("cancel_nostall", 64'(stallreq), 64'd0);
        repeat (40) @(negedge clk);
        #1;
        chk("cancel_hi", 64'(hi_o), 64'(mhi));
        chk("cancel_lo", 64'(lo_o), 64'(mlo));

        // MULTU completing under ex_hold
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd2;
        req_src1 = 32'h0001_0000;
        req_src2 = 32'h0001_0001;
        ex_hold = 1'b1;
        #1;
        chk("hold_accept_stall", 64'(stallreq), 64'd1);
        @(negedge clk);
        #1;
        chk("hold_wait_stall", 64'(stallreq), 64'd1);
        @(negedge clk);
        #1;
        chk("hold_complete_stall", 64'(stallreq), 64'd0);
        chk("hold_complete_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("hold_done_stall", 64'(stallreq), 64'd0);
            chk("hold_done_busy", 64'(busy), 64'd0);
            chk("hold_done_hi", 64'(hi_o), 64'h1);
            chk("hold_done_lo", 64'(lo_o), 64'h0001_0000);
        end
        @(negedge clk);
        ex_hold = 1'b0;
        #1;
        chk("hold_release_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = '0;
        #1;
        chk("hold_idle_busy", 64'(busy), 64'd0);
        chk("hold_final_hi", 64'(hi_o), 64'h1);
        chk("hold_final_lo", 64'(lo_o), 64'h0001_0000);
        mhi = 32'h1;
        mlo = 32'h0001_0000;
        run_op(3'd6, 32'h5555_AAAA, 32'd0, st);
        chk("post_done_mtlo", 64'(lo_o), 64'h5555_AAAA);
        mlo = 32'h5555_AAAA;

        // random ops against the architectural model
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                             : $urandom;
            dlat = $urandom_range(1, 40);
            exp_st = 0;
            case (op)
                3'd1, 3'd2: begin
                    r64 = ref_mul(op == 3'd1, a, b);
                    {mhi, mlo} = r64;
                    exp_st = L;
                end
                3'd3, 3'd4: begin
                    r64 = ref_div(op == 3'd3, a, b);
                    {mhi, mlo} = r64;
                    exp_st = dlat;
                end
                3'd5: mhi = a;
                3'd6: mlo = a;
                default: ;
            endcase
            run_op(op, a, b, st);
            chk($sformatf("rnd%0d_op%0d_hi", n, op), 64'(hi_o), 64'(mhi));
            chk($sformatf("rnd%0d_op%0d_lo", n, op), 64'(lo_o), 64'(mlo));
            chk($sformatf("rnd%0d_op%0d_stall", n, op),
                64'(st), 64'(exp_st));
        end

        // reset in the middle of a divide
        dlat = 33;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd3;
        req_src1 = 32'd77;
        req_src2 = 32'd5;
        #1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op = '0;
        rst = 1'b1;
        cancel = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        cancel = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi_o), 64'd0);
        chk("midrst_lo", 64'(lo_o), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stall", 64'(stallreq), 64'd0);
        chk("midrst_div_start", 64'(div_start), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
